// File: rtl/image_place.sv
// Places a cropped window pixel stream back into a full-frame raster at a programmable position.
// Optional ring around the window in border_color when IMAGE_PLACE_BORDER_EN is defined.
module image_place #(
   parameter int H_DISP  = 1280,
   parameter int V_DISP  = 720,
   parameter int X_WIDTH = 12,
   parameter int Y_WIDTH = 12,
   parameter int FIFO_AW = 11
) (
   input  logic               clk_vpm,
   input  logic               rst_n,
   input  logic [X_WIDTH-1:0] start_x,
   input  logic [Y_WIDTH-1:0] start_y,
   input  logic [X_WIDTH-1:0] end_x,
   input  logic [Y_WIDTH-1:0] end_y,
   input  logic [23:0]        bg_color,
`ifdef IMAGE_PLACE_BORDER_EN
   input  logic [23:0]        border_color,
`endif
   input  logic               vs_i,
   input  logic               de_i,
   input  logic [23:0]        rgb_i,
   input  logic               vs_t,
   input  logic               de_t,
   output logic               vs_o,
   output logic               de_o,
   output logic [23:0]        rgb_o,
   output logic [FIFO_AW:0]   fifo_level,
   output logic               overflow,
   output logic               underflow
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0]   LP_FULL   = {1'b1, {FIFO_AW{1'b0}}};
   localparam logic [X_WIDTH-1:0] LP_X_LAST = X_WIDTH'(H_DISP - 1);
   localparam logic [Y_WIDTH-1:0] LP_Y_LAST = Y_WIDTH'(V_DISP - 1);

   logic [23:0]        r_mem [0:DEPTH-1];
   logic [FIFO_AW-1:0] r_wr_ptr;
   logic [FIFO_AW-1:0] r_rd_ptr;
   logic [FIFO_AW:0]   r_level;
   logic               r_vs_i_d;
   logic [X_WIDTH-1:0] r_pixel_x;
   logic [Y_WIDTH-1:0] r_pixel_y;
   logic               r_vs_o;
   logic               r_de_o;
   logic [23:0]        r_rgb_o;
   logic               r_overflow;
   logic               r_underflow;

   logic        w_flush;
   logic        w_full;
   logic        w_empty;
   logic        w_hit;
   logic        w_pop;
   logic        w_wr;
   logic        w_drop;
   logic        w_starve;
   logic        w_ring;
   logic [23:0] w_head;
   logic [23:0] w_fill;
   logic [23:0] w_pix;

   // The cropped input has no backpressure: a pixel is transferred whenever de_i=1;
   // if the FIFO cannot take it the pixel is lost and flagged on overflow.
   assign w_flush  = vs_i & ~r_vs_i_d;
   assign w_full   = (r_level == LP_FULL);
   assign w_empty  = (r_level == '0);
   assign w_head   = r_mem[r_rd_ptr];

   assign w_hit    = de_t
                   & (r_pixel_x >= start_x) & (r_pixel_x < end_x)
                   & (r_pixel_y >= start_y) & (r_pixel_y < end_y);
   assign w_pop    = w_hit & ~w_empty;
   assign w_starve = w_hit & w_empty;
   assign w_wr     = de_i & ~w_flush & (~w_full | w_pop);
   assign w_drop   = de_i & ~w_flush & w_full & ~w_pop;

`ifdef IMAGE_PLACE_BORDER_EN
   logic [X_WIDTH:0] w_px_e;
   logic [X_WIDTH:0] w_sx_m1;
   logic [Y_WIDTH:0] w_py_e;
   logic [Y_WIDTH:0] w_sy_m1;
   logic             w_win_valid;
   logic             w_x_edge;
   logic             w_y_edge;
   logic             w_x_span;
   logic             w_y_span;

   // start-1 is computed one bit wider so that start=0 wraps to a value no pixel can reach.
   assign w_px_e      = {1'b0, r_pixel_x};
   assign w_py_e      = {1'b0, r_pixel_y};
   assign w_sx_m1     = {1'b0, start_x} - 1'b1;
   assign w_sy_m1     = {1'b0, start_y} - 1'b1;
   assign w_win_valid = (start_x < end_x) & (start_y < end_y);
   assign w_x_edge    = (w_px_e == w_sx_m1) | (r_pixel_x == end_x);
   assign w_y_edge    = (w_py_e == w_sy_m1) | (r_pixel_y == end_y);
   assign w_x_span    = ((r_pixel_x >= start_x) | (w_px_e == w_sx_m1)) & (r_pixel_x <= end_x);
   assign w_y_span    = ((r_pixel_y >= start_y) | (w_py_e == w_sy_m1)) & (r_pixel_y <= end_y);
   assign w_ring      = de_t & w_win_valid & ~w_hit
                      & ((w_x_edge & w_y_span) | (w_y_edge & w_x_span));
   assign w_fill      = w_ring ? border_color : bg_color;
`else
   assign w_ring      = 1'b0;
   assign w_fill      = bg_color;
`endif

   assign w_pix = w_pop ? w_head : w_fill;

   always_ff @(posedge clk_vpm) begin
      if (w_wr) begin
         r_mem[r_wr_ptr] <= rgb_i;
      end
   end

   always_ff @(posedge clk_vpm) begin
      if (!rst_n) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_level     <= '0;
         r_vs_i_d    <= 1'b0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_vs_i_d    <= vs_i;
         r_overflow  <= w_drop;
         r_underflow <= w_starve;
         if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
         end else begin
            if (w_wr) begin
               r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
               r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_pop})
               2'b10:   r_level <= r_level + 1'b1;
               2'b01:   r_level <= r_level - 1'b1;
               default: r_level <= r_level;
            endcase
         end
      end
   end

   // Raster position follows the downstream timing, not the cropped stream.
   always_ff @(posedge clk_vpm) begin
      if (!rst_n) begin
         r_pixel_x <= '0;
         r_pixel_y <= '0;
      end else if (vs_t) begin
         r_pixel_x <= '0;
         r_pixel_y <= '0;
      end else if (de_t) begin
         if (r_pixel_x == LP_X_LAST) begin
            r_pixel_x <= '0;
            r_pixel_y <= (r_pixel_y == LP_Y_LAST) ? '0 : r_pixel_y + 1'b1;
         end else begin
            r_pixel_x <= r_pixel_x + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_vpm) begin
      if (!rst_n) begin
         r_vs_o  <= 1'b0;
         r_de_o  <= 1'b0;
         r_rgb_o <= '0;
      end else begin
         r_vs_o  <= vs_t;
         r_de_o  <= de_t;
         r_rgb_o <= de_t ? w_pix : 24'h0;
      end
   end

   assign vs_o       = r_vs_o;
   assign de_o       = r_de_o;
   assign rgb_o      = r_rgb_o;
   assign fifo_level = r_level;
   assign overflow   = r_overflow;
   assign underflow  = r_underflow;

endmodule

// File: tb/tb_image_place.sv
// Directed self-checking bench for image_place on a 16x8 raster with a 16-entry FIFO.
// Define IMAGE_PLACE_BORDER_EN for both files to exercise the border ring.
module tb_image_place;

   localparam int H = 16;
   localparam int V = 8;
   localparam int AW = 4;
   localparam logic [23:0] BG  = 24'h123456;
   localparam logic [23:0] BRD = 24'hABCDEF;

   logic        clk_vpm = 1'b0;
   logic        rst_n;
   logic [11:0] start_x, end_x;
   logic [11:0] start_y, end_y;
   logic [23:0] bg_color;
   logic [23:0] border_color;
   logic        vs_i, de_i, vs_t, de_t;
   logic [23:0] rgb_i;
   logic        vs_o, de_o;
   logic [23:0] rgb_o;
   logic [AW:0] fifo_level;
   logic        overflow, underflow;

   int n_checks = 0;
   int n_fail   = 0;
   int win_sx, win_sy, win_ex, win_ey;
   int uf_cnt, of_cnt;

   image_place #(.H_DISP(H), .V_DISP(V), .X_WIDTH(12), .Y_WIDTH(12), .FIFO_AW(AW)) dut (
      .clk_vpm    (clk_vpm),
      .rst_n      (rst_n),
      .start_x    (start_x),
      .start_y    (start_y),
      .end_x      (end_x),
      .end_y      (end_y),
      .bg_color   (bg_color),
`ifdef IMAGE_PLACE_BORDER_EN
      .border_color(border_color),
`endif
      .vs_i       (vs_i),
      .de_i       (de_i),
      .rgb_i      (rgb_i),
      .vs_t       (vs_t),
      .de_t       (de_t),
      .vs_o       (vs_o),
      .de_o       (de_o),
      .rgb_o      (rgb_o),
      .fifo_level (fifo_level),
      .overflow   (overflow),
      .underflow  (underflow)
   );

   always #5 clk_vpm = ~clk_vpm;

   task automatic tick();
      @(posedge clk_vpm);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_window(input int sx, input int sy, input int ex, input int ey);
      win_sx = sx; win_sy = sy; win_ex = ex; win_ey = ey;
      start_x = 12'(sx); start_y = 12'(sy); end_x = 12'(ex); end_y = 12'(ey);
   endtask

   // vs_i pulse (flush) followed by n consecutive pixels 1..n; overflow pulses are counted.
   task automatic write_pixels(input int n);
      of_cnt = 0;
      vs_i = 1'b1; de_i = 1'b0;
      tick();
      vs_i = 1'b0;
      for (int i = 1; i <= n; i++) begin
         de_i = 1'b1; rgb_i = 24'(i);
         tick();
         if (overflow) of_cnt++;
      end
      de_i = 1'b0; rgb_i = '0;
      tick();
      if (overflow) of_cnt++;
   endtask

   function automatic bit in_window(input int x, input int y);
      return (x >= win_sx) && (x < win_ex) && (y >= win_sy) && (y < win_ey);
   endfunction

   function automatic bit on_ring(input int x, input int y);
`ifdef IMAGE_PLACE_BORDER_EN
      if (!(win_sx < win_ex && win_sy < win_ey) || in_window(x, y)) return 1'b0;
      return ((x == win_sx - 1 || x == win_ex) && y >= win_sy - 1 && y <= win_ey) ||
             ((y == win_sy - 1 || y == win_ey) && x >= win_sx - 1 && x <= win_ex);
`else
      return (x < 0) && (y < 0);
`endif
   endfunction

   // One output frame; window pixels take values 1..n_avail in raster order, then background.
   task automatic run_frame(input int n_avail);
      int idx;
      logic [23:0] exp;
      uf_cnt = 0;
      idx = 0;
      vs_t = 1'b1; de_t = 1'b0;
      tick();
      check("vs_o_frame", {31'b0, vs_o}, 32'd1);
      check("rgb_vs", {8'b0, rgb_o}, 32'd0);
      vs_t = 1'b0;
      for (int y = 0; y < V; y++) begin
         for (int x = 0; x < H; x++) begin
            if (in_window(x, y)) begin
               exp = (idx < n_avail) ? 24'(idx + 1) : BG;
               idx++;
            end else begin
               exp = on_ring(x, y) ? BRD : BG;
            end
            de_t = 1'b1;
            tick();
            if (underflow) uf_cnt++;
            check($sformatf("rgb_x%0d_y%0d", x, y), {8'b0, rgb_o}, {8'b0, exp});
            check("de_o_active", {31'b0, de_o}, 32'd1);
         end
         de_t = 1'b0;
         tick();
         if (underflow) uf_cnt++;
         check("rgb_blank", {8'b0, rgb_o}, 32'd0);
         check("de_o_blank", {31'b0, de_o}, 32'd0);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      vs_i = 1'b0; de_i = 1'b0; rgb_i = '0;
      vs_t = 1'b0; de_t = 1'b0;
      bg_color = BG; border_color = BRD;
      set_window(4, 2, 8, 4);

      // Reset held with raster timing toggling.
      for (int i = 0; i < 3; i++) begin
         vs_t = i[0]; de_t = ~i[0];
         tick();
         check("rst_vs_o", {31'b0, vs_o}, 32'd0);
         check("rst_de_o", {31'b0, de_o}, 32'd0);
         check("rst_rgb_o", {8'b0, rgb_o}, 32'd0);
         check("rst_level", {27'b0, fifo_level}, 32'd0);
         check("rst_pulses", {30'b0, overflow, underflow}, 32'd0);
      end
      vs_t = 1'b0; de_t = 1'b0;
      rst_n = 1'b1;
      tick();

      // Full window fill.
      write_pixels(8);
      check("level_after_8", {27'b0, fifo_level}, 32'd8);
      check("no_overflow_8", of_cnt, 32'd0);
      run_frame(8);
      check("level_end_8", {27'b0, fifo_level}, 32'd0);
      check("underflow_8", uf_cnt, 32'd0);

      // Starved window.
      write_pixels(5);
      run_frame(5);
      check("underflow_5", uf_cnt, 32'd3);
      check("level_end_5", {27'b0, fifo_level}, 32'd0);

      // Overflow: 17 writes into a 16-deep FIFO, then read back through a 32-pixel window.
      write_pixels(17);
      check("level_full", {27'b0, fifo_level}, 32'd16);
      check("overflow_once", of_cnt, 32'd1);
      set_window(0, 0, 16, 2);
      run_frame(16);
      check("underflow_ovf_frame", uf_cnt, 32'd16);
      check("level_end_ovf", {27'b0, fifo_level}, 32'd0);

      // Flush beats a same-cycle write.
      write_pixels(10);
      check("level_10", {27'b0, fifo_level}, 32'd10);
      vs_i = 1'b1; de_i = 1'b1; rgb_i = 24'hAAAAAA;
      tick();
      check("flush_level", {27'b0, fifo_level}, 32'd0);
      vs_i = 1'b0; de_i = 1'b0;
      tick();
      check("flush_write_ignored", {27'b0, fifo_level}, 32'd0);

      // Empty window: nothing pops, nothing underflows.
      write_pixels(4);
      set_window(5, 5, 3, 7);
      run_frame(4);
      check("empty_win_underflow", uf_cnt, 32'd0);
      check("empty_win_level", {27'b0, fifo_level}, 32'd4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/image_place.md
Name: image_place

Overview:
- Inverse of the VP window-crop stage: re-inserts a cropped pixel stream (window pixels only) into a full-frame raster at a programmable window position.
- Window pixels are buffered in an internal FIFO, then replayed into the window region of a downstream full-frame timing (vs_t/de_t).
- Pixels outside the window are filled with bg_color.
- Sits after processing blocks that operate on cropped windows, before scaler/HDMI output; single clock domain.

Parameters:
- H_DISP, 1280, active pixels per line of the output raster.
- V_DISP, 720, active lines per frame of the output raster.
- X_WIDTH, 12, width of window x coordinates.
- Y_WIDTH, 12, width of window y coordinates.
- FIFO_AW, 11, FIFO address width; depth = 2^FIFO_AW entries of 24 bits.

Ports:
- clk_vpm in 1: pixel clock, all logic.
- rst_n in 1: synchronous, active-low reset.
- start_x in X_WIDTH: window left edge, inclusive.
- start_y in Y_WIDTH: window top edge, inclusive.
- end_x in X_WIDTH: window right edge, exclusive.
- end_y in Y_WIDTH: window bottom edge, exclusive.
- bg_color in 24: fill colour outside the window.
- vs_i in 1: cropped-stream vsync, active high.
- de_i in 1: cropped-stream pixel valid.
- rgb_i in 24: cropped-stream pixel.
- vs_t in 1: output raster vsync, active high.
- de_t in 1: output raster data enable.
- vs_o out 1: registered vs_t.
- de_o out 1: registered de_t.
- rgb_o out 24: output pixel.
- fifo_level out FIFO_AW+1: current FIFO occupancy.
- overflow out 1: one-cycle pulse, write dropped.
- underflow out 1: one-cycle pulse, in-window read with FIFO empty.

Behaviour:
- Reset (rst_n=0 at a clk_vpm edge):
  - vs_o=0, de_o=0, rgb_o=0, overflow=0, underflow=0.
  - fifo_level=0; pointers=0; pixel_x=pixel_y=0.
- Write side:
  - Rising edge of vs_i (registered previous-value detect) flushes the FIFO: both pointers=0, level=0.
  - Flush takes priority over any same-cycle write or read.
  - Otherwise de_i=1 writes rgb_i if the FIFO is not full.
  - If full and no same-cycle read, the write is dropped and overflow=1 next cycle.
  - If full with a same-cycle read, the write is accepted.
- Raster counters (driven by de_t/vs_t, same rules as the crop stage):
  - vs_t=1 clears pixel_x and pixel_y.
  - de_t=1: pixel_x increments, wrapping at H_DISP-1. On wrap, pixel_y increments, wrapping at V_DISP-1.
- Window hit (combinational on current counters): start_x<=pixel_x<end_x and start_y<=pixel_y<end_y and de_t=1.
  - start>=end on either axis gives an empty window: every pixel is bg_color and no reads occur.
- Read side: FIFO is first-word-fallthrough (head visible combinationally).
  - On hit with FIFO non-empty: pop and use head.
  - On hit with FIFO empty: no pop, use bg_color, underflow=1 next cycle.
  - Simultaneous write into an empty FIFO does not bypass; it still counts as underflow.
- Output timing: latency exactly 1 cycle.
  - vs_o<=vs_t, de_o<=de_t.
  - rgb_o <= selected pixel when de_t=1, else 0.
- fifo_level: +1 on accepted write, -1 on pop, unchanged on both; 0 on flush.
- Window coordinates are sampled live. Changing them mid-frame is legal but yields an undefined picture for that frame; no lockup.
- FIFO pointers wrap modulo 2^FIFO_AW. Full = level==2^FIFO_AW, empty = level==0.

Optional Feature:
- Macro IMAGE_PLACE_BORDER_EN.
- When defined:
  - Adds input border_color[23:0].
  - Output pixels on the ring immediately outside the window (x==start_x-1 or x==end_x, with y in [start_y-1, end_y]; same for y edges) are border_color instead of bg_color.
  - Ring pixels never pop the FIFO.
  - Ring positions below 0 or at/after H_DISP/V_DISP are simply absent (no wrap).
- When undefined: no port, no ring logic, all out-of-window pixels are bg_color.

Test Plan (H_DISP=16, V_DISP=8, FIFO_AW=4):
- Reset hold 3 cycles with vs_t/de_t toggling -> vs_o=de_o=0, rgb_o=0, fifo_level=0, no pulses.
- Window (4,2)-(8,4): write 8 pixels 0x000001..0x000008 after a vs_i pulse, run one raster frame -> rows 2-3, cols 4-7 show 1..8 in order, one cycle after de_t; all else bg_color=0x123456; fifo_level ends 0.
- Same window, write only 5 pixels -> positions 6,7,8 show bg_color; underflow pulses exactly 3 times.
- Write 17 pixels with no reads -> fifo_level=16, exactly one overflow pulse; 17th pixel is absent from output.
- FIFO holding 10 entries, then vs_i rising edge with de_i=1 same cycle -> fifo_level=0 next cycle, write ignored.
- Window (5,5)-(3,7), i.e. start_x>end_x -> full frame bg_color, zero pops, zero underflow. With IMAGE_PLACE_BORDER_EN and window (4,2)-(8,4): pixel (3,2) and (8,1) equal border_color.
